// File: rtl/zero_reg_if.sv
// rtl/zero_reg_if.sv - write-side and status signal bundle for the zero_reg block
interface zero_reg_if #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
);
  logic [SIZE-1:0]  din_i;
  logic             wr_en_i;
  logic [SIZE-1:0]  dout_o;
  logic             wr_seen_o;
  logic             wr_nonzero_o;
  logic [CNT_W-1:0] wr_cnt_o;
  logic [SIZE-1:0]  last_wr_data_o;

  modport master (
    output din_i,
    output wr_en_i,
    input  dout_o,
    input  wr_seen_o,
    input  wr_nonzero_o,
    input  wr_cnt_o,
    input  last_wr_data_o
  );

  modport slave (
    input  din_i,
    input  wr_en_i,
    output dout_o,
    output wr_seen_o,
    output wr_nonzero_o,
    output wr_cnt_o,
    output last_wr_data_o
  );
endinterface

// File: rtl/zero_reg.sv
// rtl/zero_reg.sv - hardwired-zero register that discards writes but records write activity
module zero_reg #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 16
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  zero_reg_if.slave bus
);

  logic             seen_q;
  logic             nonzero_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SIZE-1:0]  last_q;

  // Read data is a constant so nothing on din_i can ever reach it.
  assign bus.dout_o         = '0;
  assign bus.wr_seen_o      = seen_q;
  assign bus.wr_nonzero_o   = nonzero_q;
  assign bus.wr_cnt_o       = cnt_q;
  assign bus.last_wr_data_o = last_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seen_q    <= 1'b0;
      nonzero_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= '0;
    end else begin
      seen_q <= bus.wr_en_i;
      if (bus.wr_en_i) begin
        last_q <= bus.din_i;
        if (|bus.din_i) begin
          nonzero_q <= 1'b1;
        end
        // Saturate at all-ones instead of wrapping back to zero.
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_zero_reg.sv
// tb/tb_zero_reg.sv - self-checking bench for zero_reg with vector table and random reference model
module tb_zero_reg;

  logic clk;
  logic rst_n;

  zero_reg_if #(.SIZE(8), .CNT_W(16)) ifa ();
  zero_reg_if #(.SIZE(8), .CNT_W(2))  ifb ();

  assign ifb.din_i   = ifa.din_i;
  assign ifb.wr_en_i = ifa.wr_en_i;

  zero_reg #(.SIZE(8), .CNT_W(16)) dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(ifa.slave));
  zero_reg #(.SIZE(8), .CNT_W(2))  dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: attempts counted as an unbounded integer, saturation applied at compare time.
  bit       m_seen;
  bit       m_nz;
  int       m_att;
  bit [7:0] m_last;

  typedef struct {
    bit       rst;
    bit       en;
    bit [7:0] din;
    bit       e_seen;
    bit       e_nz;
    int       e_cnt_a;
    int       e_cnt_b;
    bit [7:0] e_last;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (n > lim) ? lim : n;
  endfunction

  task automatic model_reset();
    m_seen = 0;
    m_nz   = 0;
    m_att  = 0;
    m_last = 8'h00;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout_a"}, 64'(ifa.dout_o), 64'h0);
    chk({tag, ".dout_b"}, 64'(ifb.dout_o), 64'h0);
    chk({tag, ".seen"},   64'(ifa.wr_seen_o), 64'(m_seen));
    chk({tag, ".nz"},     64'(ifa.wr_nonzero_o), 64'(m_nz));
    chk({tag, ".cnt_a"},  64'(ifa.wr_cnt_o), 64'(sat(m_att, 16)));
    chk({tag, ".cnt_b"},  64'(ifb.wr_cnt_o), 64'(sat(m_att, 2)));
    chk({tag, ".last"},   64'(ifa.last_wr_data_o), 64'(m_last));
    chk({tag, ".seen_b"}, 64'(ifb.wr_seen_o), 64'(m_seen));
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic cycle(input bit rst, input bit en, input logic [7:0] din);
    rst_n       = !rst;
    ifa.wr_en_i = en;
    ifa.din_i   = din;
    if (rst) model_reset();
    @(posedge clk);
    if (!rst) begin
      m_seen = en;
      if (en) begin
        m_att++;
        m_last = din;
        if (din != 8'h00) m_nz = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] last_snap;
    int       cnt_snap;

    //            rst en  din    seen nz cnt_a cnt_b last
    vecs[0]  = '{1, 1, 8'hFF, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{0, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[2]  = '{0, 1, 8'hFF, 1, 1, 1, 1, 8'hFF};
    vecs[3]  = '{0, 0, 8'h5A, 0, 1, 1, 1, 8'hFF};
    vecs[4]  = '{1, 0, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[5]  = '{0, 1, 8'h00, 1, 0, 1, 1, 8'h00};
    vecs[6]  = '{0, 1, 8'h00, 1, 0, 2, 2, 8'h00};
    vecs[7]  = '{0, 1, 8'h00, 1, 0, 3, 3, 8'h00};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 3, 3, 8'h00};
    vecs[9]  = '{0, 1, 8'h01, 1, 1, 4, 3, 8'h01};
    vecs[10] = '{0, 1, 8'h80, 1, 1, 5, 3, 8'h80};
    vecs[11] = '{0, 0, 8'h00, 0, 1, 5, 3, 8'h80};

    rst_n       = 1'b0;
    ifa.wr_en_i = 1'b0;
    ifa.din_i   = 8'h00;
    model_reset();
    @(negedge clk);
    chk("reset.dout",  64'(ifa.dout_o), 64'h0);
    chk("reset.cnt",   64'(ifa.wr_cnt_o), 64'h0);
    chk("reset.seen",  64'(ifa.wr_seen_o), 64'h0);

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].rst, vecs[i].en, vecs[i].din);
      chk($sformatf("vec%0d.dout", i),  64'(ifa.dout_o), 64'h0);
      chk($sformatf("vec%0d.seen", i),  64'(ifa.wr_seen_o), 64'(vecs[i].e_seen));
      chk($sformatf("vec%0d.nz", i),    64'(ifa.wr_nonzero_o), 64'(vecs[i].e_nz));
      chk($sformatf("vec%0d.cnt_a", i), 64'(ifa.wr_cnt_o), 64'(vecs[i].e_cnt_a));
      chk($sformatf("vec%0d.cnt_b", i), 64'(ifb.wr_cnt_o), 64'(vecs[i].e_cnt_b));
      chk($sformatf("vec%0d.last", i),  64'(ifa.last_wr_data_o), 64'(vecs[i].e_last));
    end

    // Asynchronous reset between edges after a write of 0xA5.
    cycle(0, 1, 8'hA5);
    check_model("a5");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.seen", 64'(ifa.wr_seen_o), 64'h0);
    chk("async.nz",   64'(ifa.wr_nonzero_o), 64'h0);
    chk("async.cnt",  64'(ifa.wr_cnt_o), 64'h0);
    chk("async.last", 64'(ifa.last_wr_data_o), 64'h0);
    chk("async.dout", 64'(ifa.dout_o), 64'h0);
    @(negedge clk);
    cycle(0, 1, 8'h3C);
    check_model("post_rst");

    // Idle with random data: nothing may move.
    last_snap = m_last;
    cnt_snap  = m_att;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, (i % 10 == 0) ? 8'bx : 8'($urandom));
      check_model("idle");
    end
    chk("idle.last_hold", 64'(ifa.last_wr_data_o), 64'(last_snap));
    chk("idle.cnt_hold",  64'(ifa.wr_cnt_o), 64'(cnt_snap));

    // Mixed random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0,
            ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
